// File: rtl/icm_buffer_set_del_nway_pkg.sv
// Shared types and helpers for the ICM N-way set/delete engine.
package icm_buffer_set_del_nway_pkg;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_READ,
        ST_EVAL
    } state_e;

    typedef enum logic {
        OP_SET,
        OP_DEL
    } op_e;

    // Number of bits needed to represent x (log2b(31) = 5, log2b(0) = 0).
    function automatic int log2b(input longint unsigned x);
        int r;
        r = 0;
        for (int i = 0; i < 64; i++) begin
            if ((x >> i) != 0) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/icm_buffer_set_del_nway_way_select.sv
// Combinational way selection: tag hit vector, lowest hit, lowest invalid,
// round-robin victim, and a one-hot of the way a SET request should write.
module icm_way_select
    import icm_buffer_set_del_nway_pkg::*;
#(
    parameter int WAY_NUM           = 4,
    parameter int WAY_NUM_LOG       = 2,
    parameter int CACHE_TAG_WIDTH   = 12,
    parameter int CACHE_ENTRY_WIDTH = 256,
    parameter int LINE_WIDTH        = 1 + CACHE_TAG_WIDTH + CACHE_ENTRY_WIDTH
)(
    input  logic [WAY_NUM*LINE_WIDTH-1:0] way_dout,
    input  logic [CACHE_TAG_WIDTH-1:0]    tag,
    input  logic [WAY_NUM_LOG-1:0]        repl_dout,
    output logic [WAY_NUM-1:0]            hit_vec,
    output logic [WAY_NUM-1:0]            sel_oh,
    output logic                          is_hit,
    output logic                          is_fill,
    output logic                          is_evict
);

    logic [WAY_NUM-1:0] inv_vec;
    logic [WAY_NUM-1:0] hit_oh;
    logic [WAY_NUM-1:0] inv_oh;
    logic [WAY_NUM-1:0] evict_oh;
    logic               unused_data;

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        hit_vec     = '0;
        inv_vec     = '0;
        unused_data = 1'b0;
        for (int i = 0; i < WAY_NUM; i++) begin
            inv_vec[i] = !way_dout[i*LINE_WIDTH + LINE_WIDTH - 1];
            hit_vec[i] = way_dout[i*LINE_WIDTH + LINE_WIDTH - 1] &&
                         (way_dout[i*LINE_WIDTH + CACHE_ENTRY_WIDTH +: CACHE_TAG_WIDTH] == tag);
            unused_data = unused_data ^ (^way_dout[i*LINE_WIDTH +: CACHE_ENTRY_WIDTH]);
        end
    end

    // Scanning downwards lets the lowest matching way overwrite any higher one.
    always_comb begin
        hit_oh = '0;
        inv_oh = '0;
        for (int i = WAY_NUM - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_oh    = '0;
                hit_oh[i] = 1'b1;
            end
            if (inv_vec[i]) begin
                inv_oh    = '0;
                inv_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        evict_oh            = '0;
        evict_oh[repl_dout] = 1'b1;
    end

    assign is_hit   = |hit_vec;
    assign is_fill  = !is_hit && (|inv_vec);
    assign is_evict = !is_hit && !(|inv_vec);
    assign sel_oh   = is_hit ? hit_oh : (is_fill ? inv_oh : evict_oh);

endmodule

// File: rtl/icm_buffer_set_del_nway.sv
// N-way set/delete engine for one ICM cache SRAM group: post-reset sweep,
// fair set/del arbitration, hit-aware fill/evict, invalidate on delete.
// Optional statistics counters are enabled by defining ICM_BUFFER_STAT_EN.
module icm_buffer_set_del_nway
    import icm_buffer_set_del_nway_pkg::*;
#(
    parameter int ICM_ADDR_WIDTH    = 64,
    parameter int ICM_ENTRY_NUM     = 65536,
    parameter int ICM_SLOT_SIZE     = 32,
    parameter int CACHE_ENTRY_WIDTH = 256,
    parameter int CACHE_SET_NUM     = 1024,
    parameter int WAY_NUM           = 4,
    localparam int CACHE_OFFSET_WIDTH = log2b(ICM_SLOT_SIZE - 1),
    localparam int CACHE_ADDR_WIDTH   = log2b(longint'(ICM_ENTRY_NUM) * ICM_SLOT_SIZE - 1),
    localparam int CACHE_SET_NUM_LOG  = log2b(CACHE_SET_NUM - 1),
    localparam int WAY_NUM_LOG        = (log2b(WAY_NUM - 1) > 1) ? log2b(WAY_NUM - 1) : 1,
    localparam int CACHE_TAG_WIDTH    = CACHE_ADDR_WIDTH - CACHE_OFFSET_WIDTH - CACHE_SET_NUM_LOG,
    localparam int LINE_WIDTH         = 1 + CACHE_TAG_WIDTH + CACHE_ENTRY_WIDTH
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          set_req_valid,
    output logic                          set_req_ready,
    input  logic [ICM_ADDR_WIDTH-1:0]     set_req_head,
    input  logic [CACHE_ENTRY_WIDTH-1:0]  set_req_data,
    input  logic                          del_req_valid,
    output logic                          del_req_ready,
    input  logic [ICM_ADDR_WIDTH-1:0]     del_req_head,
    output logic [WAY_NUM-1:0]            way_wen,
    output logic [CACHE_SET_NUM_LOG-1:0]  way_addr,
    output logic [LINE_WIDTH-1:0]         way_din,
    input  logic [WAY_NUM*LINE_WIDTH-1:0] way_dout,
    output logic                          repl_wen,
    output logic [CACHE_SET_NUM_LOG-1:0]  repl_addr,
    output logic [WAY_NUM_LOG-1:0]        repl_din,
    input  logic [WAY_NUM_LOG-1:0]        repl_dout,
    output logic                          init_done
`ifdef ICM_BUFFER_STAT_EN
    ,
    output logic [31:0]                   stat_set_hit,
    output logic [31:0]                   stat_set_fill,
    output logic [31:0]                   stat_set_evict,
    output logic [31:0]                   stat_del_hit,
    output logic [31:0]                   stat_del_miss
`endif
);

    state_e                       state, state_nxt;
    op_e                          req_op;
    logic [CACHE_SET_NUM_LOG-1:0] req_set;
    logic [CACHE_TAG_WIDTH-1:0]   req_tag;
    logic [CACHE_ENTRY_WIDTH-1:0] req_data;
    logic [CACHE_SET_NUM_LOG-1:0] init_cnt;
    logic                         init_done_q;
    logic                         last_del;
    logic                         grant_set, grant_del;
    logic [ICM_ADDR_WIDTH-1:0]    sel_head;
    logic [CACHE_ADDR_WIDTH-1:0]  sel_addr;
    logic [WAY_NUM-1:0]           hit_vec, sel_oh;
    logic                         is_hit, is_fill, is_evict;
    logic                         unused_head;

    // Round-robin: on a tie the side not served last wins.
    assign grant_set = set_req_valid && (!del_req_valid || last_del);
    assign grant_del = del_req_valid && !grant_set;
    assign sel_head  = grant_set ? set_req_head : del_req_head;
    assign sel_addr  = sel_head[CACHE_ADDR_WIDTH-1:0];

    assign unused_head = ^{set_req_head[ICM_ADDR_WIDTH-1:CACHE_ADDR_WIDTH],
                           set_req_head[CACHE_OFFSET_WIDTH-1:0],
                           del_req_head[ICM_ADDR_WIDTH-1:CACHE_ADDR_WIDTH],
                           del_req_head[CACHE_OFFSET_WIDTH-1:0]};

    icm_way_select #(
        .WAY_NUM           (WAY_NUM),
        .WAY_NUM_LOG       (WAY_NUM_LOG),
        .CACHE_TAG_WIDTH   (CACHE_TAG_WIDTH),
        .CACHE_ENTRY_WIDTH (CACHE_ENTRY_WIDTH),
        .LINE_WIDTH        (LINE_WIDTH)
    ) u_way_select (
        .way_dout  (way_dout),
        .tag       (req_tag),
        .repl_dout (repl_dout),
        .hit_vec   (hit_vec),
        .sel_oh    (sel_oh),
        .is_hit    (is_hit),
        .is_fill   (is_fill),
        .is_evict  (is_evict)
    );

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_INIT;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt    <= '0;
            init_done_q <= 1'b0;
            last_del    <= 1'b1;
        end else begin
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
                if (init_cnt == CACHE_SET_NUM_LOG'(CACHE_SET_NUM - 1)) init_done_q <= 1'b1;
            end
            if (state == ST_IDLE && (grant_set || grant_del)) last_del <= grant_del;
        end
    end

    // NOTE: the request holding registers carry no reset; they are only read after a handshake has loaded them.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && (grant_set || grant_del)) begin
            req_op   <= grant_set ? OP_SET : OP_DEL;
            req_set  <= sel_addr[CACHE_OFFSET_WIDTH +: CACHE_SET_NUM_LOG];
            req_tag  <= sel_addr[CACHE_ADDR_WIDTH-1 -: CACHE_TAG_WIDTH];
            req_data <= set_req_data;
        end
    end

    always_comb begin
        state_nxt     = state;
        way_wen       = '0;
        way_addr      = '0;
        way_din       = '0;
        repl_wen      = 1'b0;
        repl_addr     = '0;
        repl_din      = '0;
        set_req_ready = 1'b0;
        del_req_ready = 1'b0;
        case (state)
            ST_INIT: begin
                way_wen   = '1;
                way_addr  = init_cnt;
                repl_wen  = 1'b1;
                repl_addr = init_cnt;
                if (init_cnt == CACHE_SET_NUM_LOG'(CACHE_SET_NUM - 1)) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                set_req_ready = grant_set;
                del_req_ready = grant_del;
                if (grant_set || grant_del) state_nxt = ST_READ;
            end
            ST_READ: begin
                way_addr  = req_set;
                repl_addr = req_set;
                state_nxt = ST_EVAL;
            end
            ST_EVAL: begin
                way_addr  = req_set;
                repl_addr = req_set;
                if (req_op == OP_SET) begin
                    way_wen = sel_oh;
                    way_din = {1'b1, req_tag, req_data};
                    if (is_evict) begin
                        repl_wen = 1'b1;
                        repl_din = repl_dout + 1'b1;
                    end
                end else begin
                    way_wen = hit_vec;
                end
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_INIT;
        endcase
        // A reset cycle must never write the SRAMs, whatever state it lands in.
        if (rst) begin
            way_wen       = '0;
            way_addr      = '0;
            way_din       = '0;
            repl_wen      = 1'b0;
            repl_addr     = '0;
            repl_din      = '0;
            set_req_ready = 1'b0;
            del_req_ready = 1'b0;
        end
    end

    assign init_done = init_done_q && !rst;

`ifdef ICM_BUFFER_STAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_set_hit   <= '0;
            stat_set_fill  <= '0;
            stat_set_evict <= '0;
            stat_del_hit   <= '0;
            stat_del_miss  <= '0;
        end else if (state == ST_EVAL) begin
            if (req_op == OP_SET) begin
                if (is_hit   && stat_set_hit   != '1) stat_set_hit   <= stat_set_hit + 1'b1;
                if (is_fill  && stat_set_fill  != '1) stat_set_fill  <= stat_set_fill + 1'b1;
                if (is_evict && stat_set_evict != '1) stat_set_evict <= stat_set_evict + 1'b1;
            end else begin
                if (is_hit  && stat_del_hit  != '1) stat_del_hit  <= stat_del_hit + 1'b1;
                if (!is_hit && stat_del_miss != '1) stat_del_miss <= stat_del_miss + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icm_buffer_set_del_nway.sv
// Directed self-checking bench: 4 ways, 16 sets, 32-byte slots, with a
// behavioural 1-cycle-latency SRAM model for the way and pointer arrays.
module tb_icm_buffer_set_del_nway;

    localparam int WAY = 4;
    localparam int SETS = 16;
    localparam int EW = 32;
    localparam int TW = 12;
    localparam int LW = 1 + TW + EW;

    logic              clk;
    logic              rst;
    logic              set_req_valid, set_req_ready;
    logic [63:0]       set_req_head;
    logic [EW-1:0]     set_req_data;
    logic              del_req_valid, del_req_ready;
    logic [63:0]       del_req_head;
    logic [WAY-1:0]    way_wen;
    logic [3:0]        way_addr;
    logic [LW-1:0]     way_din;
    logic [WAY*LW-1:0] way_dout;
    logic              repl_wen;
    logic [3:0]        repl_addr;
    logic [1:0]        repl_din, repl_dout;
    logic              init_done;
`ifdef ICM_BUFFER_STAT_EN
    logic [31:0] stat_set_hit, stat_set_fill, stat_set_evict, stat_del_hit, stat_del_miss;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    icm_buffer_set_del_nway #(
        .ICM_ADDR_WIDTH    (64),
        .ICM_ENTRY_NUM     (65536),
        .ICM_SLOT_SIZE     (32),
        .CACHE_ENTRY_WIDTH (EW),
        .CACHE_SET_NUM     (SETS),
        .WAY_NUM           (WAY)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .set_req_valid (set_req_valid),
        .set_req_ready (set_req_ready),
        .set_req_head  (set_req_head),
        .set_req_data  (set_req_data),
        .del_req_valid (del_req_valid),
        .del_req_ready (del_req_ready),
        .del_req_head  (del_req_head),
        .way_wen       (way_wen),
        .way_addr      (way_addr),
        .way_din       (way_din),
        .way_dout      (way_dout),
        .repl_wen      (repl_wen),
        .repl_addr     (repl_addr),
        .repl_din      (repl_din),
        .repl_dout     (repl_dout),
        .init_done     (init_done)
`ifdef ICM_BUFFER_STAT_EN
        ,
        .stat_set_hit   (stat_set_hit),
        .stat_set_fill  (stat_set_fill),
        .stat_set_evict (stat_set_evict),
        .stat_del_hit   (stat_del_hit),
        .stat_del_miss  (stat_del_miss)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM model: registered read, read-before-write.
    logic [LW-1:0] mem [WAY][SETS];
    logic [1:0]    repl_mem [SETS];

    always @(posedge clk) begin
        for (int w = 0; w < WAY; w++) begin
            way_dout[w*LW +: LW] <= mem[w][way_addr];
            if (way_wen[w]) mem[w][way_addr] <= way_din;
        end
        repl_dout <= repl_mem[repl_addr];
        if (repl_wen) repl_mem[repl_addr] <= repl_din;
    end

    function automatic logic [LW-1:0] mk(input int tag, input logic [EW-1:0] data);
        logic [TW-1:0] t;
        t = TW'(tag);
        return {1'b1, t, data};
    endfunction

    function automatic logic [63:0] hd(input int tag, input int set);
        return (64'(tag) << 9) | (64'(set) << 5);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge with the DUT in IDLE and inputs already driven;
    // returns at the negedge where the DUT is back in IDLE.
    task automatic run_op(input string nm, input bit exp_sr, input bit exp_dr,
                          input int set_idx, input logic [WAY-1:0] exp_wen,
                          input logic [LW-1:0] exp_din, input bit exp_rwen,
                          input logic [1:0] exp_rdin, input bit drop);
        #1;
        chk({nm, ":set_ready"}, 64'(set_req_ready), 64'(exp_sr));
        chk({nm, ":del_ready"}, 64'(del_req_ready), 64'(exp_dr));
        @(negedge clk);
        if (drop) begin
            set_req_valid = 1'b0;
            del_req_valid = 1'b0;
        end
        #1;
        chk({nm, ":read_wen"}, 64'(way_wen), 64'(0));
        chk({nm, ":read_addr"}, 64'(way_addr), 64'(set_idx));
        @(negedge clk);
        #1;
        chk({nm, ":wen"}, 64'(way_wen), 64'(exp_wen));
        if (exp_wen != '0) chk({nm, ":din"}, 64'(way_din), 64'(exp_din));
        chk({nm, ":repl_wen"}, 64'(repl_wen), 64'(exp_rwen));
        if (exp_rwen) chk({nm, ":repl_din"}, 64'(repl_din), 64'(exp_rdin));
        @(negedge clk);
    endtask

    task automatic do_set(input string nm, input int tag, input int set, input logic [EW-1:0] data,
                          input logic [WAY-1:0] exp_wen, input bit exp_rwen, input logic [1:0] exp_rdin);
        set_req_valid = 1'b1;
        set_req_head  = hd(tag, set);
        set_req_data  = data;
        run_op(nm, 1'b1, 1'b0, set, exp_wen, mk(tag, data), exp_rwen, exp_rdin, 1'b1);
    endtask

    task automatic do_del(input string nm, input int tag, input int set, input logic [WAY-1:0] exp_wen);
        del_req_valid = 1'b1;
        del_req_head  = hd(tag, set);
        run_op(nm, 1'b0, 1'b1, set, exp_wen, '0, 1'b0, 2'd0, 1'b1);
    endtask

    initial begin
        // Garbage before the sweep: every line valid, every pointer 3.
        for (int w = 0; w < WAY; w++)
            for (int s = 0; s < SETS; s++) mem[w][s] = '1;
        for (int s = 0; s < SETS; s++) repl_mem[s] = 2'd3;

        rst = 1'b1;
        set_req_valid = 1'b1;
        set_req_head  = hd(0, 9);
        set_req_data  = 32'hAAAA_0001;
        del_req_valid = 1'b1;
        del_req_head  = hd(0, 9);
        repeat (3) @(negedge clk);
        #1;
        chk("rst:wen", 64'(way_wen), 64'(0));
        chk("rst:repl_wen", 64'(repl_wen), 64'(0));
        chk("rst:set_ready", 64'(set_req_ready), 64'(0));
        chk("rst:del_ready", 64'(del_req_ready), 64'(0));
        chk("rst:init_done", 64'(init_done), 64'(0));
        chk("rst:way_addr", 64'(way_addr), 64'(0));

        // Sweep: sets 0..15 cleared, set request held but never accepted.
        @(negedge clk);
        rst = 1'b0;
        del_req_valid = 1'b0;
        for (int i = 0; i < SETS; i++) begin
            #1;
            chk($sformatf("init%0d:wen", i), 64'(way_wen), 64'hF);
            chk($sformatf("init%0d:addr", i), 64'(way_addr), 64'(i));
            chk($sformatf("init%0d:din", i), 64'(way_din), 64'(0));
            chk($sformatf("init%0d:repl_wen", i), 64'(repl_wen), 64'(1));
            chk($sformatf("init%0d:repl_din", i), 64'(repl_din), 64'(0));
            chk($sformatf("init%0d:set_ready", i), 64'(set_req_ready), 64'(0));
            chk($sformatf("init%0d:init_done", i), 64'(init_done), 64'(0));
            @(negedge clk);
        end
        #1;
        chk("init:done_cycle17", 64'(init_done), 64'(1));

        // Set 9: fills, hit rewrite, evictions, deletes.
        do_set("s_t0",  0, 9, 32'hAAAA_0001, 4'b0001, 1'b0, 2'd0);
        do_set("s_t1",  1, 9, 32'h1111_0001, 4'b0010, 1'b0, 2'd0);
        do_set("s_t2",  2, 9, 32'h2222_0002, 4'b0100, 1'b0, 2'd0);
        do_set("s_t3",  3, 9, 32'h3333_0003, 4'b1000, 1'b0, 2'd0);
        do_set("s_t0b", 0, 9, 32'hBBBB_000B, 4'b0001, 1'b0, 2'd0);
        do_set("s_t4",  4, 9, 32'h4444_0004, 4'b0001, 1'b1, 2'd1);
        do_set("s_t5",  5, 9, 32'h5555_0005, 4'b0010, 1'b1, 2'd2);
        do_del("d_t0",  0, 9, 4'b0000);
        do_del("d_t2",  2, 9, 4'b0100);
        do_set("s_t6",  6, 9, 32'h6666_0006, 4'b0100, 1'b0, 2'd0);

        // Both valid continuously: last grant was a set, so del leads.
        set_req_valid = 1'b1;
        set_req_head  = hd(7, 9);
        set_req_data  = 32'hCCCC_000C;
        del_req_valid = 1'b1;
        del_req_head  = hd(5, 9);
        run_op("arb0_del", 1'b0, 1'b1, 9, 4'b0010, '0, 1'b0, 2'd0, 1'b0);
        run_op("arb1_set", 1'b1, 1'b0, 9, 4'b0010, mk(7, 32'hCCCC_000C), 1'b0, 2'd0, 1'b0);
        run_op("arb2_del", 1'b0, 1'b1, 9, 4'b0000, '0, 1'b0, 2'd0, 1'b0);
        run_op("arb3_set", 1'b1, 1'b0, 9, 4'b0010, mk(7, 32'hCCCC_000C), 1'b0, 2'd0, 1'b0);

        // Reset in EVAL of a delete that would hit way 1.
        del_req_head = hd(7, 9);
        #1;
        chk("rstev:del_ready", 64'(del_req_ready), 64'(1));
        @(negedge clk);
        #1;
        chk("rstev:read_wen", 64'(way_wen), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstev:eval_wen", 64'(way_wen), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstev:init_wen", 64'(way_wen), 64'hF);
        chk("rstev:init_addr", 64'(way_addr), 64'(0));
        chk("rstev:set_ready", 64'(set_req_ready), 64'(0));
        chk("rstev:del_ready", 64'(del_req_ready), 64'(0));
        chk("rstev:init_done", 64'(init_done), 64'(0));
        set_req_valid = 1'b0;
        del_req_valid = 1'b0;
        repeat (SETS) @(negedge clk);
        #1;
        chk("rstev:done", 64'(init_done), 64'(1));
        @(negedge clk);

        // Pointer wrap on set 3: fill 4 ways, then 4 evictions 0,1,2,3 -> 0.
        for (int k = 0; k < WAY; k++)
            do_set($sformatf("w_fill%0d", k), k + 1, 3, 32'h0300_0000 + 32'(k), 4'(1 << k), 1'b0, 2'd0);
        for (int k = 0; k < WAY; k++)
            do_set($sformatf("w_evict%0d", k), k + 5, 3, 32'h0350_0000 + 32'(k), 4'(1 << k), 1'b1, 2'((k + 1) % WAY));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
